spi_word_rx: RTL

- SPI slave receiver for the counter readout link; the receiving end of the SS/SCLK/MOSI/done stream that the counter board's serial controller sends.
- Oversamples SS, SCLK and MOSI in the local clock domain and shifts bits in MSB-first (SPI mode 0).
- Validates the frame length and presents each complete word to downstream logic through a valid/ack handshake.
- Sits on the capture or monitor side of the link, next to logging or display logic.

---
 rtl/spi_word_rx_pkg.sv | 13 +
 rtl/spi_word_rx_sync_edge.sv | 39 +++
 rtl/spi_word_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spi_word_rx_pkg.sv
// Shared constants and state encoding for the counter readout link receiver.
package spi_word_rx_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/spi_word_rx_sync_edge.sv
// Multi-stage synchronizer with an edge-detect register and rise/fall strobes.
// o_primed goes high once the chain and the edge register hold only real
// samples, so edges produced by the reset-value flush can be ignored.
module spi_word_rx_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_sync,
  output logic o_primed,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;
  logic [STAGES:0]   r_fill;

  // Synchronizer chain, edge-detect register and fill tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
      r_fill  <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
      r_fill  <= {r_fill[STAGES-1:0], 1'b1};
    end
  end

  assign o_sync   = r_chain[STAGES-1];
  assign o_primed = r_fill[STAGES];
  assign o_rise_c = r_chain[STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_word_rx.sv
// SPI mode-0 slave word receiver: oversampled inputs, MSB-first shift,
// frame-length check and valid/ack hand-off of each good word.
module spi_word_rx
  import spi_word_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ss_n,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic             data_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  logic w_ss_sync, w_ss_primed, w_ss_rise, w_ss_fall;
  logic w_sclk_sync, w_sclk_primed, w_sclk_rise, w_sclk_fall;
  logic w_mosi_sync, w_mosi_primed, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  rx_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_rx, w_rx_nxt;
  logic             r_dv, w_dv_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic             r_ovr, w_ovr_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_capture, w_ovr_set;

  spi_word_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .i_d(ss_n),
    .o_sync(w_ss_sync), .o_primed(w_ss_primed),
    .o_rise_c(w_ss_rise), .o_fall_c(w_ss_fall)
  );

  spi_word_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_d(sclk),
    .o_sync(w_sclk_sync), .o_primed(w_sclk_primed),
    .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
  );

  // Same depth as sclk so the sampled bit lines up with the detected rise.
  spi_word_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_d(mosi),
    .o_sync(w_mosi_sync), .o_primed(w_mosi_primed),
    .o_rise_c(w_mosi_rise), .o_fall_c(w_mosi_fall)
  );

  assign w_unused = ^{w_sclk_sync, w_sclk_primed, w_sclk_fall,
                      w_mosi_primed, w_mosi_rise, w_mosi_fall};

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_rx    <= '0;
      r_dv    <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rx    <= w_rx_nxt;
      r_dv    <= w_dv_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state, shift/count, frame evaluation and handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_rx_nxt    = r_rx;
    w_dv_nxt    = r_dv;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = r_ovr;
    w_capture   = 1'b0;
    w_ovr_set   = 1'b0;

    case (r_state)
      WAIT_IDLE: begin
        if (w_ss_primed && w_ss_sync) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (w_ss_fall) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          if (r_cnt == CNT_W'(WIDTH)) begin
            if (!r_dv || rd_ack) w_capture = 1'b1;
            else                 w_ovr_set = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else if (w_sclk_rise) begin
          w_shift_nxt = {r_shift[WIDTH-2:0], w_mosi_sync};
          if (r_cnt != CNT_W'(WIDTH + 1)) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = WAIT_IDLE;
    endcase

    if (w_capture) begin
      w_rx_nxt = r_shift;
      w_dv_nxt = 1'b1;
    end else if (rd_ack && r_dv) begin
      w_dv_nxt = 1'b0;
    end

    if (w_ovr_set)           w_ovr_nxt = 1'b1;
    else if (rd_ack && r_dv) w_ovr_nxt = 1'b0;

    w_busy_nxt = (w_state_nxt == SHIFT);
  end

  assign rx_data    = r_rx;
  assign data_valid = r_dv;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = r_busy;

endmodule
